// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions: FSM encodings, frame edge
// numbering and the latched frame payload. The receive path uses the same
// edge numbering.
package ps2_host_tx_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_INHIBIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_START     = 3'd2;
  localparam logic [STATE_W-1:0] ST_BITS      = 3'd3;
  localparam logic [STATE_W-1:0] ST_ACK       = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 3'd5;

  localparam int unsigned EDGE_W          = 4;
  localparam int unsigned PS2_FRAME_EDGES = 11;
  localparam int unsigned PS2_STOP_EDGE   = 10;
  localparam int unsigned PS2_PARITY_EDGE = 9;

  // Command byte plus its odd-parity bit, latched on accept.
  typedef struct packed {
    logic [7:0] data;
    logic       parity;
  } ps2_frame_t;

  // Odd parity: set when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Line level to present after falling edge number edge_idx (1..10).
  // Edges 1..8 carry d0..d7, edge 9 parity, edge 10 the stop bit (high).
  function automatic logic frame_bit(input ps2_frame_t frame,
                                     input logic [EDGE_W-1:0] edge_idx);
    logic bit_v;
    bit_v = 1'b1;
    if ((edge_idx >= 4'd1) && (edge_idx <= 4'd8)) begin
      bit_v = frame.data[3'(edge_idx - 4'd1)];
    end else if (edge_idx == EDGE_W'(PS2_PARITY_EDGE)) begin
      bit_v = frame.parity;
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 pin with a registered
// falling-edge strobe.
//   clk_i    core clock
//   reset_i  synchronous active-high reset (lines idle high)
//   pin_i    raw pin level
//   level_o  synchronized level
//   fall_o   one-cycle strobe, aligned with level_o going low
module ps2_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic fall_q;

  // Reset to the idle-high level so releasing reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      fall_q <= sync_q & ~meta_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues a start bit,
// shifts one byte LSB first with odd parity and stop on device clock falling
// edges, then checks the device ACK. At chip level the *_oe outputs drive the
// SB_IO OUTPUT_ENABLE with D_OUT_0 tied low (open drain).
//   clk_core, reset         core clock, synchronous active-high reset
//   tx_data, tx_valid       byte to send and request
//   tx_ready                high in IDLE; accept = tx_valid && tx_ready
//   tx_done, tx_err         one-cycle completion / failure pulses
//   busy                    high whenever not IDLE
//   ps2_clk_in, ps2_data_in raw pin levels
//   ps2_clk_oe, ps2_data_oe 1 = pull the pin low
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 256,
  parameter int unsigned TIMEOUT_CYCLES = 32768
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned CNT_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX       = '1;

  logic [STATE_W-1:0] state_q,   state_d;
  logic [CNT_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [WD_W-1:0]    wd_q,      wd_d;
  ps2_frame_t         frame_q,   frame_d;
  logic               ack_ok_q,  ack_ok_d;
  logic               clk_oe_q,  clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;

  logic              clk_level;
  logic              clk_fall;
  logic              data_level;
  logic              data_fall_unused;
  logic [EDGE_W-1:0] edge_inc;
  logic              wd_run;
  logic              wd_expire;

  // Pin synchronizers; the transmitter only needs the data line's level.
  ps2_sync_edge u_sync_clk (
    .clk_i   (clk_core),
    .reset_i (reset),
    .pin_i   (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk_i   (clk_core),
    .reset_i (reset),
    .pin_i   (ps2_data_in),
    .level_o (data_level),
    .fall_o  (data_fall_unused)
  );

  // Saturating edge count as it will read after the current edge.
  assign edge_inc = (edge_cnt_q == '1) ? edge_cnt_q : edge_cnt_q + 4'd1;

  // Watchdog runs from the START cycle on, so an expiry with no device edges
  // lands tx_err exactly TIMEOUT_CYCLES cycles after START. An edge in the
  // expiry cycle wins.
  assign wd_run    = (state_q == ST_START) || (state_q == ST_BITS) ||
                     (state_q == ST_ACK)   || (state_q == ST_WAIT_IDLE);
  assign wd_expire = wd_run && !clk_fall && (wd_q >= WD_LAST);

  // State and output registers.
  always_ff @(posedge clk_core) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inh_cnt_q  <= '0;
      edge_cnt_q <= '0;
      wd_q       <= '0;
      frame_q    <= '0;
      ack_ok_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      wd_q       <= wd_d;
      frame_q    <= frame_d;
      ack_ok_q   <= ack_ok_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic. Line drives are decoded for the state
  // being entered, so the registered pins already match that state.
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    edge_cnt_d = edge_cnt_q;
    wd_d       = wd_q;
    frame_d    = frame_q;
    ack_ok_d   = ack_ok_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (!wd_run || clk_fall) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + WD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          frame_d   = '{data: tx_data, parity: odd_parity(tx_data)};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == INHIBIT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end else begin
          inh_cnt_d = inh_cnt_q + CNT_W'(1);
        end
      end

      ST_START: begin
        edge_cnt_d = '0;
        state_d    = ST_BITS;
      end

      ST_BITS: begin
        if (clk_fall) begin
          edge_cnt_d = edge_inc;
          data_oe_d  = ~frame_bit(frame_q, edge_inc);
          if (edge_inc == EDGE_W'(PS2_STOP_EDGE)) begin
            state_d = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        // Device pulls data low across the final falling edge to acknowledge.
        if (clk_fall && (edge_inc == EDGE_W'(PS2_FRAME_EDGES))) begin
          edge_cnt_d = edge_inc;
          ack_ok_d   = ~data_level;
          state_d    = ST_WAIT_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          done_d  = ack_ok_q;
          err_d   = ~ack_ok_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wd_expire) begin
      done_d  = 1'b0;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    // Both lines are always released in IDLE.
    if (state_d == ST_IDLE) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = ~ready_d;
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
